s2_issue_scheduler: RTL and testbench

S2_ISSUE_SCHEDULER -- requirements
Module: s2_issue_scheduler

---
 rtl/s2_issue_scheduler.sv | 173 +++++++++++++++++
 tb/tb_s2_issue_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/s2_issue_scheduler.sv
// Stage-2 issue scheduler: packs up to three bool symbols per issue slot, or issues one CDF symbol.
// Optional partial-group idle flush is enabled by defining S2_SCHED_TIMEOUT_EN.
module s2_issue_scheduler #(
  parameter int RANGE_WIDTH    = 16,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bool,
  input  logic                       in_last,
  input  logic [SYMBOL_WIDTH-1:0]    in_symbol,
  input  logic [4*RANGE_WIDTH:0]     in_cdf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_bool_1,
  output logic                       out_bool_2,
  output logic                       out_bool_3,
  output logic [SYMBOL_WIDTH-1:0]    out_symbol_1,
  output logic [SYMBOL_WIDTH-1:0]    out_symbol_2,
  output logic [SYMBOL_WIDTH-1:0]    out_symbol_3,
  output logic [4*RANGE_WIDTH:0]     out_cdf
);

  // state    | meaning
  // ST_IDLE  | accumulator empty, CDF may issue directly
  // ST_FILL  | 1-2 bools held, more bools accepted
  // ST_FULL  | 3 bools held or flush pending, waiting for output slot
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FULL} acc_st_e;

  localparam int CW = 4*RANGE_WIDTH + 1;

  acc_st_e                 acc_st;
  logic [1:0]              acc_cnt_q, acc_cnt_d;
  logic [SYMBOL_WIDTH-1:0] acc_sym_q [3];
  logic [SYMBOL_WIDTH-1:0] acc_sym_d [3];
  logic                    flush_q, flush_d;
  logic                    out_valid_q, out_valid_d;
  logic [2:0]              out_bool_q, out_bool_d;
  logic [SYMBOL_WIDTH-1:0] out_sym_q [3];
  logic [SYMBOL_WIDTH-1:0] out_sym_d [3];
  logic [CW-1:0]           out_cdf_q, out_cdf_d;

  logic out_free, bool_acc, cdf_acc, cdf_block, do_flush;
  logic flush_base, tmo_fire, set_flush;
  logic [2:0] grp_flag;

  always_comb begin
    if (flush_q || acc_cnt_q == 2'd3) acc_st = ST_FULL;
    else if (acc_cnt_q != 2'd0)       acc_st = ST_FILL;
    else                              acc_st = ST_IDLE;
  end

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = in_bool ? (acc_st != ST_FULL) : (acc_st == ST_IDLE && out_free);
  assign bool_acc  = in_valid && in_bool && in_ready;
  assign cdf_acc   = in_valid && !in_bool && in_ready;
  // A CDF waiting behind a partial group forces that group out first.
  assign cdf_block = in_valid && !in_bool && (acc_cnt_q != 2'd0) && !flush_q;
  assign do_flush  = flush_q && out_free;
  assign flush_base = (bool_acc && (acc_cnt_q == 2'd2 || in_last)) || cdf_block;
  assign set_flush  = flush_base || tmo_fire;

  always_comb begin
    for (int k = 0; k < 3; k++) grp_flag[k] = (acc_cnt_q > 2'(k));
  end

`ifdef S2_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Down-counter reloaded on every bool accept; terminal count raises the flush.
  always_comb begin
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;
    if (flush_base || do_flush) begin
      tmo_d = '0;
    end else if (bool_acc) begin
      tmo_d = TW'(TIMEOUT_CYCLES);
    end else if (acc_st == ST_FILL && tmo_q != '0) begin
      if (tmo_q == TW'(1)) begin
        tmo_fire = 1'b1;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    acc_sym_d   = acc_sym_q;
    flush_d     = flush_q;
    out_valid_d = out_valid_q;
    out_bool_d  = out_bool_q;
    out_sym_d   = out_sym_q;
    out_cdf_d   = out_cdf_q;

    if (do_flush) begin
      out_valid_d = 1'b1;
      out_bool_d  = grp_flag;
      out_cdf_d   = '0;
      for (int k = 0; k < 3; k++) begin
        out_sym_d[k] = grp_flag[k] ? acc_sym_q[k] : '0;
        acc_sym_d[k] = '0;
      end
      acc_cnt_d = 2'd0;
      flush_d   = 1'b0;
    end else if (cdf_acc) begin
      out_valid_d  = 1'b1;
      out_bool_d   = 3'b000;
      out_sym_d[0] = in_symbol;
      out_sym_d[1] = '0;
      out_sym_d[2] = '0;
      out_cdf_d    = in_cdf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bool_acc) begin
      for (int k = 0; k < 3; k++) begin
        if (acc_cnt_q == 2'(k)) acc_sym_d[k] = in_symbol;
      end
      acc_cnt_d = acc_cnt_q + 2'd1;
    end

    if (set_flush) flush_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt_q   <= 2'd0;
      flush_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_bool_q  <= 3'b000;
      out_cdf_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        acc_sym_q[k] <= '0;
        out_sym_q[k] <= '0;
      end
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      flush_q     <= flush_d;
      out_valid_q <= out_valid_d;
      out_bool_q  <= out_bool_d;
      out_cdf_q   <= out_cdf_d;
      for (int k = 0; k < 3; k++) begin
        acc_sym_q[k] <= acc_sym_d[k];
        out_sym_q[k] <= out_sym_d[k];
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_bool_1   = out_bool_q[0];
  assign out_bool_2   = out_bool_q[1];
  assign out_bool_3   = out_bool_q[2];
  assign out_symbol_1 = out_sym_q[0];
  assign out_symbol_2 = out_sym_q[1];
  assign out_symbol_3 = out_sym_q[2];
  assign out_cdf      = out_cdf_q;

endmodule

// File: tb/tb_s2_issue_scheduler.sv
// Directed bench for s2_issue_scheduler; covers the S2_SCHED_TIMEOUT_EN build when that macro is defined.
module tb_s2_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_bool, in_last;
  logic [3:0]  in_symbol;
  logic [64:0] in_cdf;
  logic        out_valid, out_ready;
  logic        out_bool_1, out_bool_2, out_bool_3;
  logic [3:0]  out_symbol_1, out_symbol_2, out_symbol_3;
  logic [64:0] out_cdf;

  int n_chk = 0;
  int n_bad = 0;
  logic seen;

  localparam logic [64:0] CDF_A = {1'b1, 16'h0100, 16'h0203, 16'h0405, 16'h0607};
  localparam logic [64:0] CDF_B = {1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444};

  s2_issue_scheduler dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bool(in_bool), .in_last(in_last),
    .in_symbol(in_symbol), .in_cdf(in_cdf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bool_1(out_bool_1), .out_bool_2(out_bool_2), .out_bool_3(out_bool_3),
    .out_symbol_1(out_symbol_1), .out_symbol_2(out_symbol_2), .out_symbol_3(out_symbol_3),
    .out_cdf(out_cdf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bool(input logic [3:0] sym, input logic last);
    in_valid  = 1'b1;
    in_bool   = 1'b1;
    in_symbol = sym;
    in_last   = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [2:0] flags();
    return {out_bool_3, out_bool_2, out_bool_1};
  endfunction

  function automatic logic [11:0] syms();
    return {out_symbol_3, out_symbol_2, out_symbol_1};
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_bool = 1'b0; in_last = 1'b0;
    in_symbol = '0; in_cdf = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_syms", syms(), 0);
    chk("rst_cdf", out_cdf, 0);
    @(negedge clk); reset = 1'b1;

    // three bools 1,0,1 back to back
    drive_bool(4'd1, 1'b0); #1 chk("b3_rdy", in_ready, 1);
    @(negedge clk); drive_bool(4'd0, 1'b0);
    @(negedge clk); drive_bool(4'd1, 1'b0);
    @(negedge clk); idle(); #1;
    chk("b3_flush_rdy", in_ready, 0);
    chk("b3_novalid", out_valid, 0);
    @(negedge clk);
    chk("b3_valid", out_valid, 1);
    chk("b3_flags", flags(), 3'b111);
    chk("b3_syms", syms(), 12'h101);
    chk("b3_cdf", out_cdf, 0);
    @(negedge clk); chk("b3_drain", out_valid, 0);

    // partial group then CDF (with in_last, treated as a normal CDF)
    drive_bool(4'd1, 1'b0);
    @(negedge clk); drive_bool(4'd0, 1'b0);
    @(negedge clk);
    in_bool = 1'b0; in_valid = 1'b1; in_symbol = 4'd9; in_last = 1'b1; in_cdf = CDF_A;
    #1 chk("cdf_stall0", in_ready, 0);
    @(negedge clk);
    chk("cdf_stall1", in_ready, 0);
    chk("cdf_novalid", out_valid, 0);
    @(negedge clk);
    chk("grp_valid", out_valid, 1);
    chk("grp_flags", flags(), 3'b011);
    chk("grp_syms", syms(), 12'h001);
    chk("grp_cdf", out_cdf, 0);
    chk("cdf_rdy", in_ready, 1);
    @(negedge clk);
    chk("cdf_valid", out_valid, 1);
    chk("cdf_flags", flags(), 3'b000);
    chk("cdf_syms", syms(), 12'h009);
    chk("cdf_data", out_cdf, CDF_A);
    idle();
    @(negedge clk); chk("cdf_drain", out_valid, 0);

    // single bool with in_last
    drive_bool(4'd5, 1'b1);
    @(negedge clk); idle(); chk("last_novalid", out_valid, 0);
    @(negedge clk);
    chk("last_valid", out_valid, 1);
    chk("last_flags", flags(), 3'b001);
    chk("last_syms", syms(), 12'h005);
    @(negedge clk); chk("last_drain", out_valid, 0);

    // one bool then idle
    drive_bool(4'd3, 1'b0);
    @(negedge clk); idle();
`ifdef S2_SCHED_TIMEOUT_EN
    repeat (8) @(negedge clk);
    chk("tmo_early", out_valid, 0);
    @(negedge clk);
    chk("tmo_valid", out_valid, 1);
    chk("tmo_flags", flags(), 3'b001);
    chk("tmo_syms", syms(), 12'h003);
    @(negedge clk); chk("tmo_drain", out_valid, 0);
`else
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_tmo", seen, 0);
    drive_bool(4'd8, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    chk("late_valid", out_valid, 1);
    chk("late_flags", flags(), 3'b011);
    chk("late_syms", syms(), 12'h083);
    @(negedge clk); chk("late_drain", out_valid, 0);
`endif

    // backpressure: output held, CDF refused, bools capped at 3
    out_ready = 1'b0;
    drive_bool(4'd7, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_flags", flags(), 3'b001);
    in_bool = 1'b0; in_valid = 1'b1; in_symbol = 4'd2; in_cdf = CDF_B;
    #1 chk("bp_cdf_rdy", in_ready, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive_bool(4'(10 + i), (i == 4));
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", {out_bool_1, out_symbol_1, out_symbol_2, out_cdf}, {1'b1, 4'd7, 4'd0, 65'd0});
    end
    idle(); #1 chk("bp_full_rdy", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_grp_valid", out_valid, 1);
    chk("bp_grp_flags", flags(), 3'b111);
    chk("bp_grp_syms", syms(), 12'hCBA);
    @(negedge clk);
    chk("bp_drain", out_valid, 0);
    in_bool = 1'b0; #1 chk("bp_empty_rdy", in_ready, 1);

    // reset with output valid and two bools pending
    out_ready = 1'b0;
    drive_bool(4'd2, 1'b1);
    @(negedge clk); idle();
    @(negedge clk); drive_bool(4'd4, 1'b0);
    @(negedge clk); drive_bool(4'd6, 1'b0);
    @(negedge clk); idle();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_rdy", in_ready, 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_flags", flags(), 0);
    chk("mid_rst_syms", syms(), 0);
    chk("mid_rst_cdf", out_cdf, 0);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);
    in_bool = 1'b0; #1 chk("post_rst_rdy", in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
